mac_acc: RTL and testbench

- Signed multiply-accumulate unit: each clock, multiplies a signed 4-bit activation IN by a signed 4-bit weight W.
- Adds the product into a 12-bit signed running accumulator that drives OUT.
- Intended as a single processing element for small dot-product / neural-layer datapaths; instantiated positionally, so port declaration order is fixed as IN, W, clk, rstb, OUT.

---
 rtl/mac_acc.sv | 35 +++
 tb/tb_mac_acc.sv | 105 ++++++++++
 2 files changed

// File: rtl/mac_acc.sv
// mac_acc: signed multiply-accumulate processing element.
// Ports: IN   - signed activation sample (IN_W bits)
//        W    - signed weight sample (W_W bits)
//        clk  - rising-edge clock
//        rstb - synchronous active-low reset, clears the accumulator
//        OUT  - registered signed accumulator value (ACC_W bits)
module mac_acc #(
  parameter int IN_W     = 4,
  parameter int W_W      = 4,
  parameter int ACC_W    = 12,
  parameter bit SATURATE = 1'b0
) (
  input  logic [IN_W-1:0]  IN,
  input  logic [W_W-1:0]   W,
  input  logic             clk,
  input  logic             rstb,
  output logic [ACC_W-1:0] OUT
);
  localparam int P_W = IN_W + W_W;
  logic [P_W-1:0] prod;
  logic [ACC_W:0] sum;
  logic ovf;
  logic [ACC_W-1:0] nxt;
  // Operands are sign-extended to the product width so the low P_W bits of the
  // unsigned multiply equal the exact signed product.
  assign prod = {{W_W{IN[IN_W-1]}}, IN} * {{IN_W{W[W_W-1]}}, W};
  assign sum = {OUT[ACC_W-1], OUT} + {{(ACC_W+1-P_W){prod[P_W-1]}}, prod};
  // One guard bit above the accumulator: overflow when it disagrees with the sign.
  assign ovf = sum[ACC_W] ^ sum[ACC_W-1];
  assign nxt = (SATURATE && ovf) ? (sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}})
                                 : sum[ACC_W-1:0];
  always_ff @(posedge clk)
    if (!rstb) OUT <= '0;
    else OUT <= nxt;
endmodule

// File: tb/tb_mac_acc.sv
// tb_mac_acc: scoreboard bench for mac_acc in wrap and saturate configurations.
module tb_mac_acc;
  logic clk = 1'b0;
  logic rstb = 1'b0;
  logic [3:0] in_s = '0;
  logic [3:0] w_s = '0;
  logic [11:0] out_wrap;
  logic [11:0] out_sat;
  int checks = 0;
  int errors = 0;
  int q_wrap[$];
  int q_sat[$];
  int m_wrap = 0;
  int m_sat = 0;

  always #5 clk = ~clk;

  mac_acc #(.IN_W(4), .W_W(4), .ACC_W(12), .SATURATE(1'b0)) dut_wrap (
    .IN(in_s), .W(w_s), .clk(clk), .rstb(rstb), .OUT(out_wrap));
  mac_acc #(.IN_W(4), .W_W(4), .ACC_W(12), .SATURATE(1'b1)) dut_sat (
    .IN(in_s), .W(w_s), .clk(clk), .rstb(rstb), .OUT(out_sat));

  function automatic int wrap12(int v);
    return v > 2047 ? v - 4096 : (v < -2048 ? v + 4096 : v);
  endfunction

  function automatic int sat12(int v);
    return v > 2047 ? 2047 : (v < -2048 ? -2048 : v);
  endfunction

  task automatic step(input bit r, input int a, input int b);
    int p;
    logic [3:0] av;
    logic [3:0] bv;
    @(negedge clk);
    av = a[3:0];
    bv = b[3:0];
    rstb = r;
    in_s = av;
    w_s = bv;
    p = $signed(av) * $signed(bv);
    m_wrap = r ? wrap12(m_wrap + p) : 0;
    m_sat = r ? sat12(m_sat + p) : 0;
    q_wrap.push_back(m_wrap);
    q_sat.push_back(m_sat);
  endtask

  initial begin
    forever begin
      int e0;
      int e1;
      @(posedge clk);
      #1;
      if (q_wrap.size() > 0) begin
        e0 = q_wrap.pop_front();
        e1 = q_sat.pop_front();
        checks += 2;
        if (int'($signed(out_wrap)) != e0) begin
          errors++;
          $display("FAIL wrap_out: got %0d expected %0d at %0t", $signed(out_wrap), e0, $time);
        end
        if (int'($signed(out_sat)) != e1) begin
          errors++;
          $display("FAIL sat_out: got %0d expected %0d at %0t", $signed(out_sat), e1, $time);
        end
      end
    end
  end

  initial begin
    int budget;
    step(0, 5, 3);
    step(0, 5, 3);
    repeat (3) step(1, 3, 2);
    step(0, 0, 0);
    step(1, 7, -8);
    step(1, -8, -8);
    step(1, -1, 5);
    step(1, 0, 5);
    step(1, 6, 0);
    step(0, 0, 0);
    repeat (33) step(1, -8, -8);
    step(1, 7, -8);
    repeat (40) step(1, 7, -8);
    step(0, 0, 0);
    repeat (3) step(1, 3, 2);
    step(0, 7, 6);
    step(1, 1, 2);
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 24) != 0, $urandom_range(0, 15), $urandom_range(0, 15));
    for (int i = 0; i < 60; i++)
      step(1, ($urandom_range(0, 1) != 0) ? -8 : 7, -8);
    budget = 10;
    while (q_wrap.size() > 0 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (q_wrap.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d outputs pending, expected 0", q_wrap.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
